// File: rtl/tcb_arb_rr.sv
// tcb_arb_rr: round-robin arbiter sharing one TCB subordinate port among MPN managers.
// Define TCB_ARB_PRIORITY_EN for fixed lowest-index-first priority (no rotating pointer).
`timescale 1ns/1ps
module tcb_arb_rr #(
    parameter int MPN = 2,
    parameter int ABW = 32,
    parameter int DBW = 32,
    parameter int BEW = DBW/8,
    parameter int DLY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MPN-1:0]     man_vld,
    output logic [MPN-1:0]     man_rdy,
    input  logic [MPN-1:0]     man_lck,
    input  logic [MPN-1:0]     man_wen,
    input  logic [MPN*ABW-1:0] man_adr,
    input  logic [MPN*BEW-1:0] man_ben,
    input  logic [MPN*DBW-1:0] man_wdt,
    output logic [MPN*DBW-1:0] man_rdt,
    output logic [MPN-1:0]     man_err,
    output logic               sub_vld,
    input  logic               sub_rdy,
    output logic               sub_lck,
    output logic               sub_wen,
    output logic [ABW-1:0]     sub_adr,
    output logic [BEW-1:0]     sub_ben,
    output logic [DBW-1:0]     sub_wdt,
    input  logic [DBW-1:0]     sub_rdt,
    input  logic               sub_err
);

    localparam int IW = (MPN > 1) ? $clog2(MPN) : 1;

    logic [ABW-1:0] adr_a [MPN];
    logic [BEW-1:0] ben_a [MPN];
    logic [DBW-1:0] wdt_a [MPN];

    for (genvar i = 0; i < MPN; i++) begin : g_unpack
        assign adr_a[i] = man_adr[i*ABW +: ABW];
        assign ben_a[i] = man_ben[i*BEW +: BEW];
        assign wdt_a[i] = man_wdt[i*DBW +: DBW];
    end

    logic          lkd;
    logic [IW-1:0] own;
    logic [IW-1:0] base;
    logic [IW-1:0] gnt;
    logic          gnt_vld;
    logic          trn;

    assign trn = sub_vld & sub_rdy;

`ifdef TCB_ARB_PRIORITY_EN
    assign base = '0;
`else
    logic [IW-1:0] ptr;
    assign base = ptr;

    // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (trn && !lkd)
            ptr <= (int'(gnt) == MPN-1) ? '0 : gnt + 1'b1;
    end
`endif

    // NOTE: gnt and gnt_vld get defaults before any branch so no path leaves them unassigned (no latch).
    always_comb begin : p_grant
        logic [IW-1:0] idx;
        idx     = '0;
        gnt     = base;
        gnt_vld = 1'b0;
        if (lkd) begin
            gnt     = own;
            gnt_vld = 1'b1;
        end else begin
            for (int k = 0; k < MPN; k++) begin
`ifdef TCB_ARB_PRIORITY_EN
                idx = IW'(k);
`else
                idx = IW'((int'(base) + k) % MPN);
`endif
                if (!gnt_vld && man_vld[idx]) begin
                    gnt     = idx;
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    // With no requester gnt falls back to base, so request fields still come from a defined manager.
    assign sub_vld = man_vld[gnt];
    assign sub_lck = man_lck[gnt];
    assign sub_wen = man_wen[gnt];
    assign sub_adr = adr_a[gnt];
    assign sub_ben = ben_a[gnt];
    assign sub_wdt = wdt_a[gnt];

    for (genvar i = 0; i < MPN; i++) begin : g_rdy
        assign man_rdy[i] = sub_rdy & gnt_vld & (gnt == IW'(i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lkd <= 1'b0;
            own <= '0;
        end else if (trn) begin
            if (lkd) begin
                if (!man_lck[gnt])
                    lkd <= 1'b0;
            end else if (man_lck[gnt]) begin
                lkd <= 1'b1;
                own <= gnt;
            end
        end
    end

    logic          rsp_vld;
    logic [IW-1:0] rsp_idx;

    if (DLY > 0) begin : g_pipe
        logic          pipe_vld [DLY];
        logic [IW-1:0] pipe_idx [DLY];

        // NOTE: the index stages are reset alongside the valids; it is cheap here and keeps the pipe fully defined.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s < DLY; s++) begin
                    pipe_vld[s] <= 1'b0;
                    pipe_idx[s] <= '0;
                end
            end else begin
                pipe_vld[0] <= trn;
                pipe_idx[0] <= gnt;
                for (int s = 1; s < DLY; s++) begin
                    pipe_vld[s] <= pipe_vld[s-1];
                    pipe_idx[s] <= pipe_idx[s-1];
                end
            end
        end

        assign rsp_vld = pipe_vld[DLY-1];
        assign rsp_idx = pipe_idx[DLY-1];
    end else begin : g_comb
        assign rsp_vld = trn;
        assign rsp_idx = gnt;
    end

    for (genvar i = 0; i < MPN; i++) begin : g_rsp
        logic sel;
        assign sel                   = rsp_vld & (rsp_idx == IW'(i));
        assign man_rdt[i*DBW +: DBW] = sel ? sub_rdt : {DBW{1'bx}};
        assign man_err[i]            = sel & sub_err;
    end

endmodule

// File: tb/tb_tcb_arb_rr.sv
// Bench for tcb_arb_rr: two instances (DLY=1, DLY=2) driven in parallel and checked against a grant/lock/history model.
`timescale 1ns/1ps
module tb_tcb_arb_rr;

    localparam int MPN = 2;

    logic        clk;
    logic        rst;
    logic [1:0]  man_vld, man_lck, man_wen;
    logic [63:0] man_adr, man_wdt;
    logic [7:0]  man_ben;
    logic        sub_rdy;
    logic [31:0] sub_rdt;
    logic        sub_err;

    logic [1:0]  d1_rdy, d1_err, d2_rdy, d2_err;
    logic [63:0] d1_rdt, d2_rdt;
    logic        d1_vld, d1_lck, d1_wen, d2_vld, d2_lck, d2_wen;
    logic [31:0] d1_adr, d1_wdt, d2_adr, d2_wdt;
    logic [3:0]  d1_ben, d2_ben;

    tcb_arb_rr #(.MPN(2), .ABW(32), .DBW(32), .BEW(4), .DLY(1)) dut1 (
        .clk(clk), .rst(rst),
        .man_vld(man_vld), .man_rdy(d1_rdy), .man_lck(man_lck), .man_wen(man_wen),
        .man_adr(man_adr), .man_ben(man_ben), .man_wdt(man_wdt),
        .man_rdt(d1_rdt), .man_err(d1_err),
        .sub_vld(d1_vld), .sub_rdy(sub_rdy), .sub_lck(d1_lck), .sub_wen(d1_wen),
        .sub_adr(d1_adr), .sub_ben(d1_ben), .sub_wdt(d1_wdt),
        .sub_rdt(sub_rdt), .sub_err(sub_err)
    );

    tcb_arb_rr #(.MPN(2), .ABW(32), .DBW(32), .BEW(4), .DLY(2)) dut2 (
        .clk(clk), .rst(rst),
        .man_vld(man_vld), .man_rdy(d2_rdy), .man_lck(man_lck), .man_wen(man_wen),
        .man_adr(man_adr), .man_ben(man_ben), .man_wdt(man_wdt),
        .man_rdt(d2_rdt), .man_err(d2_err),
        .sub_vld(d2_vld), .sub_rdy(sub_rdy), .sub_lck(d2_lck), .sub_wen(d2_wen),
        .sub_adr(d2_adr), .sub_ben(d2_ben), .sub_wdt(d2_wdt),
        .sub_rdt(sub_rdt), .sub_err(sub_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: arbitration state and a history of which manager transferred each cycle.
    int m_ptr, m_own;
    bit m_lkd;
    int hist[$];
    int m_sel;
    bit m_gv;

    task automatic reset_model();
        m_ptr = 0;
        m_own = 0;
        m_lkd = 1'b0;
        hist.delete();
    endtask

    function automatic bit vld_of(int i);
        return ((man_vld >> i) & 2'b01) != 2'b00;
    endfunction

    function automatic bit lck_of(int i);
        return ((man_lck >> i) & 2'b01) != 2'b00;
    endfunction

    task automatic model_grant();
`ifdef TCB_ARB_PRIORITY_EN
        m_sel = 0;
`else
        m_sel = m_ptr;
`endif
        m_gv = 1'b0;
        if (m_lkd) begin
            m_sel = m_own;
            m_gv  = 1'b1;
        end else begin
            for (int k = 0; k < MPN; k++) begin
`ifdef TCB_ARB_PRIORITY_EN
                int j = k;
`else
                int j = (m_ptr + k) % MPN;
`endif
                if (!m_gv && vld_of(j)) begin
                    m_sel = j;
                    m_gv  = 1'b1;
                end
            end
        end
    endtask

    function automatic int resp_for(int d);
        if (hist.size() >= d) return hist[hist.size() - d];
        return -1;
    endfunction

    task automatic check_dut(string tag, int d, logic [1:0] rdy, logic vld, logic lck, logic wen,
                             logic [31:0] adr, logic [3:0] ben, logic [31:0] wdt,
                             logic [63:0] rdt, logic [1:0] err);
        logic [1:0] exp_rdy;
        int r;
        exp_rdy = (m_gv && sub_rdy) ? (2'b01 << m_sel) : 2'b00;
        check({tag, "_man_rdy"}, rdy, exp_rdy);
        check({tag, "_sub_vld"}, vld, vld_of(m_sel));
        check({tag, "_sub_lck"}, lck, lck_of(m_sel));
        check({tag, "_sub_wen"}, wen, ((man_wen >> m_sel) & 2'b01) != 2'b00);
        check({tag, "_sub_adr"}, adr, 32'(man_adr >> (m_sel * 32)));
        check({tag, "_sub_ben"}, ben, 4'(man_ben >> (m_sel * 4)));
        check({tag, "_sub_wdt"}, wdt, 32'(man_wdt >> (m_sel * 32)));
        r = resp_for(d);
        for (int i = 0; i < MPN; i++) begin
            check($sformatf("%s_man_err%0d", tag, i), (err >> i) & 2'b01, (r == i) ? sub_err : 1'b0);
            if (r == i)
                check($sformatf("%s_man_rdt%0d", tag, i), 32'(rdt >> (i * 32)), sub_rdt);
        end
    endtask

    task automatic model_update();
        bit t;
        if (rst) begin
            reset_model();
            return;
        end
        t = m_gv && vld_of(m_sel) && sub_rdy;
        if (t && !m_lkd) m_ptr = (m_sel + 1) % MPN;
        if (t) begin
            if (m_lkd) begin
                if (!lck_of(m_sel)) m_lkd = 1'b0;
            end else if (lck_of(m_sel)) begin
                m_lkd = 1'b1;
                m_own = m_sel;
            end
        end
        hist.push_back(t ? m_sel : -1);
    endtask

    task automatic tick(input bit use_exp, input string nm, input logic [1:0] exp_rdy);
        @(negedge clk);
        if (use_exp) check(nm, d1_rdy, exp_rdy);
        model_grant();
        check_dut("d1", 1, d1_rdy, d1_vld, d1_lck, d1_wen, d1_adr, d1_ben, d1_wdt, d1_rdt, d1_err);
        check_dut("d2", 2, d2_rdy, d2_vld, d2_lck, d2_wen, d2_adr, d2_ben, d2_wdt, d2_rdt, d2_err);
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        logic [1:0]  vld;
        logic [1:0]  lck;
        logic [1:0]  wen;
        logic        rdy;
        logic [31:0] adr0;
        logic [1:0]  exp_rr;
        logic [1:0]  exp_pr;
    } vec_t;

    vec_t tbl [16];

    initial begin
        tbl[0]  = '{2'b11, 2'b00, 2'b00, 1'b1, 32'h00, 2'b01, 2'b01};
        tbl[1]  = '{2'b11, 2'b00, 2'b00, 1'b1, 32'h04, 2'b10, 2'b01};
        tbl[2]  = '{2'b11, 2'b00, 2'b00, 1'b1, 32'h08, 2'b01, 2'b01};
        tbl[3]  = '{2'b11, 2'b00, 2'b00, 1'b1, 32'h0C, 2'b10, 2'b01};
        tbl[4]  = '{2'b10, 2'b00, 2'b00, 1'b1, 32'h00, 2'b10, 2'b10};
        tbl[5]  = '{2'b10, 2'b00, 2'b00, 1'b1, 32'h00, 2'b10, 2'b10};
        tbl[6]  = '{2'b10, 2'b00, 2'b00, 1'b1, 32'h00, 2'b10, 2'b10};
        tbl[7]  = '{2'b10, 2'b00, 2'b00, 1'b1, 32'h00, 2'b10, 2'b10};
        tbl[8]  = '{2'b11, 2'b00, 2'b00, 1'b0, 32'h00, 2'b00, 2'b00};
        tbl[9]  = '{2'b11, 2'b00, 2'b00, 1'b0, 32'h00, 2'b00, 2'b00};
        tbl[10] = '{2'b11, 2'b00, 2'b00, 1'b0, 32'h00, 2'b00, 2'b00};
        tbl[11] = '{2'b11, 2'b01, 2'b01, 1'b1, 32'h10, 2'b01, 2'b01};
        tbl[12] = '{2'b10, 2'b00, 2'b00, 1'b1, 32'h10, 2'b01, 2'b01};
        tbl[13] = '{2'b11, 2'b00, 2'b00, 1'b1, 32'h14, 2'b01, 2'b01};
        tbl[14] = '{2'b11, 2'b00, 2'b00, 1'b1, 32'h18, 2'b10, 2'b01};
        tbl[15] = '{2'b11, 2'b00, 2'b00, 1'b1, 32'h1C, 2'b01, 2'b01};

        rst     = 1'b1;
        man_vld = 2'b00;
        man_lck = 2'b00;
        man_wen = 2'b00;
        man_adr = {32'h0000_0100, 32'h0};
        man_ben = 8'hFF;
        man_wdt = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
        sub_rdy = 1'b0;
        sub_rdt = 32'h0;
        sub_err = 1'b0;
        reset_model();
        tick(1'b1, "reset_rdy", 2'b00);
        tick(1'b0, "", 2'b00);
        rst = 1'b0;

        for (int k = 0; k < 16; k++) begin
            man_vld = tbl[k].vld;
            man_lck = tbl[k].lck;
            man_wen = tbl[k].wen;
            sub_rdy = tbl[k].rdy;
            man_adr = {32'h0000_0100, tbl[k].adr0};
            sub_rdt = $urandom;
            sub_err = 1'($urandom);
`ifdef TCB_ARB_PRIORITY_EN
            tick(1'b1, $sformatf("tbl%0d_rdy", k), tbl[k].exp_pr);
`else
            tick(1'b1, $sformatf("tbl%0d_rdy", k), tbl[k].exp_rr);
`endif
        end

        for (int n = 0; n < 400; n++) begin
            man_vld = 2'($urandom);
            man_lck = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            man_wen = 2'($urandom);
            man_adr = {$urandom, $urandom};
            man_wdt = {$urandom, $urandom};
            man_ben = 8'($urandom);
            sub_rdy = ($urandom_range(0, 3) != 0);
            sub_rdt = $urandom;
            sub_err = 1'($urandom);
            tick(1'b0, "", 2'b00);
        end

        // Reset with a read in flight: the stale response must never surface.
        man_lck = 2'b00;
        man_vld = 2'b00;
        rst = 1'b1;
        reset_model();
        tick(1'b0, "", 2'b00);
        rst = 1'b0;
        man_vld = 2'b01;
        man_wen = 2'b00;
        sub_rdy = 1'b1;
        sub_err = 1'b1;
        sub_rdt = 32'hDEAD_BEEF;
        tick(1'b1, "inflight_rdy", 2'b01);
        man_vld = 2'b00;
        rst = 1'b1;
        reset_model();
        tick(1'b0, "", 2'b00);
        rst = 1'b0;
        tick(1'b0, "", 2'b00);
        tick(1'b0, "", 2'b00);
        man_vld = 2'b11;
        tick(1'b1, "post_rst_rdy", 2'b01);
`ifdef TCB_ARB_PRIORITY_EN
        tick(1'b1, "post_rst_rdy2", 2'b01);
`else
        tick(1'b1, "post_rst_rdy2", 2'b10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tcb_arb_rr.md
Name: tcb_arb_rr

Overview:
- Round-robin arbiter that shares one TCB subordinate port between MPN TCB manager ports.
- Grants one manager per cycle and forwards its request with zero added request latency.
- Tracks in-flight transfers so each DLY-cycle-delayed response is routed back to the manager that issued it.
- Sits between CPU/DMA/VIP managers and a single memory or peripheral subordinate.

Parameters:
- MPN, 2, number of manager ports (2..16)
- ABW, 32, address bus width
- DBW, 32, data bus width
- BEW, DBW/8, byte enable width
- DLY, 1, subordinate response delay in cycles (0..4); must match the subordinate

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- man_vld  in  MPN  per-manager request valid
- man_rdy  out  MPN  per-manager ready
- man_lck  in  MPN  per-manager arbitration lock
- man_wen  in  MPN  per-manager write enable
- man_adr  in  MPN*ABW  per-manager address, manager i at [i*ABW+:ABW]
- man_ben  in  MPN*BEW  per-manager byte enable
- man_wdt  in  MPN*DBW  per-manager write data
- man_rdt  out  MPN*DBW  per-manager read data
- man_err  out  MPN  per-manager error
- sub_vld  out  1  subordinate valid
- sub_rdy  in  1  subordinate ready
- sub_lck  out  1  forwarded lock
- sub_wen  out  1  subordinate write enable
- sub_adr  out  ABW  subordinate address
- sub_ben  out  BEW  subordinate byte enable
- sub_wdt  out  DBW  subordinate write data
- sub_rdt  in  DBW  subordinate read data
- sub_err  in  1  subordinate error

Behaviour:
- Transfer: trn = vld & rdy on any port. Response is due DLY cycles after trn; DLY=0 means the response arrives in the same cycle.
- Grant (combinational):
  - If the lock register is set, grant = own.
  - Otherwise grant goes to the first requesting manager at or after ptr, searching upward and wrapping at MPN-1 -> 0.
  - No requesters: sub_vld=0 and no grant; sub_adr/wen/ben/wdt are driven from manager ptr.
- Forwarding:
  - sub_vld = man_vld[grant]; sub_* request fields and sub_lck are muxed from the granted manager.
  - man_rdy[i] = sub_rdy & (i==grant); ungranted managers see rdy=0.
- Pointer ptr (reg, log2 MPN bits): on sub transfer without lock, ptr <= grant+1, wrapping to 0 after MPN-1.
- Lock (reg lkd plus reg own):
  - On sub transfer with man_lck[grant]=1: lkd <= 1, own <= grant.
  - On a transfer by own with lck=0: lkd <= 0.
  - While locked, other managers are starved even if own drops vld.
- Response routing, DLY>0:
  - Shift pipeline of {valid, index}; stage 0 loads {trn, grant} every cycle.
  - Output stage s = pipe[DLY-1]. man_rdt[i] = sub_rdt and man_err[i] = sub_err when s.valid and s.index==i; otherwise man_rdt[i] = 'x and man_err[i] = 0.
- Response routing, DLY=0: responses are routed combinationally with the current grant.
- Back-to-back transfers from different managers are allowed every cycle, giving full throughput.
- Reset (async): ptr=0, lkd=0, own=0, all pipeline valids=0.
  - All outputs then derive combinationally: man_rdy=0 unless sub_rdy and grant, man_err=0.
  - Responses in flight when reset asserts are discarded.
- Simultaneous events: a transfer completing while new managers assert vld is handled as follows. The pointer update and the new grant take effect the next cycle; the current cycle's grant never changes after sub_rdy is sampled.

Optional Feature:
- Macro: TCB_ARB_PRIORITY_EN.
- Defined: the ptr register is removed and grant is fixed-priority, lowest index wins. Lock behaviour is unchanged.
- Undefined: round-robin as above.

Test Plan:
- MPN=2, DLY=1, both managers vld continuously, sub_rdy=1 -> grants alternate 0,1,0,1; each man_rdt matches the data returned one cycle after its own transfer.
- Only manager 1 requests with sub_rdy=1 for 4 cycles -> 4 consecutive transfers on manager 1; man_rdy[0]=0 throughout.
- Manager 0 writes adr 0x10 with lck=1, then reads adr 0x14 with lck=0, while manager 1 is vld throughout -> manager 1 is not granted until the cycle after the manager 0 unlocking transfer.
- sub_rdy held 0 for 3 cycles with both managers requesting -> grant stays stable, ptr does not move, no man_rdy asserted.
- Reset asserted while a DLY=2 read is in flight -> no man_err/rdt response delivered; ptr=0 after release.
- With TCB_ARB_PRIORITY_EN defined and both managers vld continuously -> manager 0 gets every grant and manager 1 is starved.
